// File: rtl/dp_tap_pkg.sv
// dp_tap_pkg: shared types and constants for the debug-port TAP controller.
//   tap_state_t  - the sixteen IEEE 1149.1 TAP states
//   IR_EXTEST    - instruction code selecting the BSR with mode=1
//   IR_SAMPLE    - instruction code selecting the BSR with mode=0
//   ir_bypass()  - all-ones BYPASS pattern for a given IR width
package dp_tap_pkg;

   typedef enum logic [3:0] {
      TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PAU_DR, EX2_DR, UPD_DR,
      SEL_IR, CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR
   } tap_state_t;

   localparam int IR_EXTEST = 0;
   localparam int IR_SAMPLE = 1;

   function automatic logic [31:0] ir_bypass(input int unsigned width);
      logic [31:0] ones;
      ones = '1;
      return ones >> (32 - width);
   endfunction

endpackage

// File: rtl/dp_tap_sync.sv
// dp_tap_sync: 2-flop synchronizer for a bundle of asynchronous pins, with an
// optional edge detector on bit 0 (a third flop compared against stage 2).
//   iclk, ireset - internal clock, async active-high reset (flops clear to 0)
//   d            - asynchronous inputs
//   q            - synchronized outputs (stage 2)
//   rise, fall   - single-cycle edge pulses of q[0]; tied 0 when EDGE_EN=0
module dp_tap_sync #(
   parameter int WIDTH   = 1,
   parameter bit EDGE_EN = 1'b0
) (
   input  logic             iclk,
   input  logic             ireset,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q,
   output logic             rise,
   output logic             fall
);
   logic [WIDTH-1:0] s1, s2;

   always_ff @(posedge iclk or posedge ireset) begin
      if (ireset) begin
         s1 <= '0;
         s2 <= '0;
      end else begin
         s1 <= d;
         s2 <= s1;
      end
   end

   assign q = s2;

   generate
      if (EDGE_EN) begin : g_edge
         logic s3;
         always_ff @(posedge iclk or posedge ireset) begin
            if (ireset) s3 <= 1'b0;
            else        s3 <= s2[0];
         end
         assign rise = s2[0] & ~s3;
         assign fall = ~s2[0] & s3;
      end else begin : g_no_edge
         assign rise = 1'b0;
         assign fall = 1'b0;
      end
   endgenerate

endmodule

// File: rtl/dp_tap_ctrl.sv
// dp_tap_ctrl: JTAG TAP controller for the debug port. Oversamples TCK/TMS/TDI
// in the iclk domain, runs the 1149.1 TAP machine, holds IR and bypass, muxes
// TDO and drives the boundary-scan chain controls.
// Optional feature macro: DP_TAP_TRST_EN (adds the synchronized trst pin).
//   iclk, ireset        - internal clock, async active-high reset
//   tck, tms, tdi       - JTAG pins, asynchronous to iclk
//   trst                - JTAG test reset, active-high (DP_TAP_TRST_EN only)
//   tdo, tdo_oe         - serial out and its enable, updated on TCK fall
//   bsr_sdi, bsr_sdo    - serial data to / from the BSR chain
//   mode                - 1 while the instruction is EXTEST
//   shift_dr            - Shift-DR level, aligned with clk_dr
//   clk_dr, update_dr   - one-iclk BSR strobes (BSR instructions only)
//   ir                  - current instruction
//
// state  | meaning
// TLR    | test-logic-reset, ir forced to BYPASS
// RTI    | run-test/idle
// SEL_DR | select DR scan
// CAP_DR | capture DR (bypass cleared, BSR capture strobe)
// SH_DR  | shift DR
// EX1_DR | exit1 DR
// PAU_DR | pause DR
// EX2_DR | exit2 DR
// UPD_DR | update DR (BSR update strobe on TCK fall)
// SEL_IR | select IR scan
// CAP_IR | capture IR (shift register loads 0..01)
// SH_IR  | shift IR
// EX1_IR | exit1 IR
// PAU_IR | pause IR
// EX2_IR | exit2 IR
// UPD_IR | update IR (ir loads on TCK fall)
module dp_tap_ctrl
   import dp_tap_pkg::*;
#(
   parameter int IR_WIDTH = 4
) (
   input  logic                iclk,
   input  logic                ireset,
   input  logic                tck,
   input  logic                tms,
   input  logic                tdi,
`ifdef DP_TAP_TRST_EN
   input  logic                trst,
`endif
   output logic                tdo,
   output logic                tdo_oe,
   output logic                bsr_sdi,
   input  logic                bsr_sdo,
   output logic                mode,
   output logic                shift_dr,
   output logic                clk_dr,
   output logic                update_dr,
   output logic [IR_WIDTH-1:0] ir
);
   localparam logic [IR_WIDTH-1:0] IR_BYP = IR_WIDTH'(ir_bypass(IR_WIDTH));
   localparam logic [IR_WIDTH-1:0] IR_CAP = IR_WIDTH'(1);
   localparam logic [IR_WIDTH-1:0] IR_EXT = IR_WIDTH'(IR_EXTEST);
   localparam logic [IR_WIDTH-1:0] IR_SMP = IR_WIDTH'(IR_SAMPLE);

   tap_state_t          state, state_nxt;
   logic [IR_WIDTH-1:0] ir_sr;
   logic                byp;
   logic                tck_rise, tck_fall;
   logic                tms_s, tdi_s, tap_rst;
   logic                sync_unused;
   logic                bsr_sel;

`ifdef DP_TAP_TRST_EN
   localparam int SYNC_W = 4;
   logic [SYNC_W-1:0] pins_s;
   dp_tap_sync #(.WIDTH(SYNC_W), .EDGE_EN(1'b1)) u_sync (
      .iclk(iclk), .ireset(ireset), .d({trst, tdi, tms, tck}),
      .q(pins_s), .rise(tck_rise), .fall(tck_fall)
   );
   assign tap_rst = pins_s[3];
`else
   localparam int SYNC_W = 3;
   logic [SYNC_W-1:0] pins_s;
   dp_tap_sync #(.WIDTH(SYNC_W), .EDGE_EN(1'b1)) u_sync (
      .iclk(iclk), .ireset(ireset), .d({tdi, tms, tck}),
      .q(pins_s), .rise(tck_rise), .fall(tck_fall)
   );
   assign tap_rst = 1'b0;
`endif

   // tck itself is only consumed through the edge pulses
   assign sync_unused = pins_s[0];
   assign tms_s       = pins_s[1];
   assign tdi_s       = pins_s[2];

   assign bsr_sel = (ir == IR_EXT) || (ir == IR_SMP);
   assign mode    = (ir == IR_EXT);

   always_ff @(posedge iclk or posedge ireset) begin
      if (ireset)       state <= TLR;
      else if (tap_rst) state <= TLR;
      else              state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (tck_rise) begin
         case (state)
            TLR:     state_nxt = tms_s ? TLR    : RTI;
            RTI:     state_nxt = tms_s ? SEL_DR : RTI;
            SEL_DR:  state_nxt = tms_s ? SEL_IR : CAP_DR;
            CAP_DR:  state_nxt = tms_s ? EX1_DR : SH_DR;
            SH_DR:   state_nxt = tms_s ? EX1_DR : SH_DR;
            EX1_DR:  state_nxt = tms_s ? UPD_DR : PAU_DR;
            PAU_DR:  state_nxt = tms_s ? EX2_DR : PAU_DR;
            EX2_DR:  state_nxt = tms_s ? UPD_DR : SH_DR;
            UPD_DR:  state_nxt = tms_s ? SEL_DR : RTI;
            SEL_IR:  state_nxt = tms_s ? TLR    : CAP_IR;
            CAP_IR:  state_nxt = tms_s ? EX1_IR : SH_IR;
            SH_IR:   state_nxt = tms_s ? EX1_IR : SH_IR;
            EX1_IR:  state_nxt = tms_s ? UPD_IR : PAU_IR;
            PAU_IR:  state_nxt = tms_s ? EX2_IR : PAU_IR;
            EX2_IR:  state_nxt = tms_s ? UPD_IR : SH_IR;
            UPD_IR:  state_nxt = tms_s ? SEL_DR : RTI;
            default: state_nxt = TLR;
         endcase
      end
   end

   always_ff @(posedge iclk or posedge ireset) begin
      if (ireset) begin
         ir        <= IR_BYP;
         ir_sr     <= '0;
         byp       <= 1'b0;
         bsr_sdi   <= 1'b0;
         tdo       <= 1'b0;
         tdo_oe    <= 1'b0;
         clk_dr    <= 1'b0;
         update_dr <= 1'b0;
         shift_dr  <= 1'b0;
      end else if (tap_rst) begin
         ir        <= IR_BYP;
         ir_sr     <= '0;
         byp       <= 1'b0;
         bsr_sdi   <= 1'b0;
         tdo       <= 1'b0;
         tdo_oe    <= 1'b0;
         clk_dr    <= 1'b0;
         update_dr <= 1'b0;
         shift_dr  <= 1'b0;
      end else begin
         clk_dr    <= tck_rise & bsr_sel & ((state == CAP_DR) || (state == SH_DR));
         update_dr <= tck_fall & bsr_sel & (state == UPD_DR);
         // one cycle behind state so it matches the clk_dr it accompanies
         shift_dr  <= (state == SH_DR);
         if (tck_rise) begin
            bsr_sdi <= tdi_s;
            case (state)
               CAP_IR:  ir_sr <= IR_CAP;
               SH_IR:   ir_sr <= {tdi_s, ir_sr[IR_WIDTH-1:1]};
               CAP_DR:  byp   <= 1'b0;
               SH_DR:   byp   <= tdi_s;
               default: ;
            endcase
         end
         // covers both sitting in TLR and the transition into it
         if (state_nxt == TLR)                 ir <= IR_BYP;
         else if (tck_fall && state == UPD_IR) ir <= ir_sr;
         if (tck_fall) begin
            tdo_oe <= 1'b0;
            tdo    <= 1'b0;
            if (state == SH_IR) begin
               tdo_oe <= 1'b1;
               tdo    <= ir_sr[0];
            end else if (state == SH_DR) begin
               tdo_oe <= 1'b1;
               tdo    <= bsr_sel ? bsr_sdo : byp;
            end
         end
      end
   end

endmodule

// File: tb/tb_dp_tap_ctrl.sv
module tb_dp_tap_ctrl;
   localparam int IRW = 4;
   localparam logic [7:0] PINS = 8'h3C;
   localparam logic [IRW-1:0] BYPC = '1;

   localparam int TLR=0, RTI=1, SDR=2, CDR=3, SHDR=4, E1DR=5, PDR=6, E2DR=7, UDR=8;
   localparam int SIR=9, CIR=10, SHIR=11, E1IR=12, PIR=13, E2IR=14, UIR=15;
   localparam int NX0[16] = '{RTI, RTI, CDR, SHDR, SHDR, PDR, PDR, SHDR, RTI,
                              CIR, SHIR, SHIR, PIR, PIR, SHIR, RTI};
   localparam int NX1[16] = '{TLR, SDR, SIR, E1DR, E1DR, UDR, E2DR, UDR, SDR,
                              TLR, E1IR, E1IR, UIR, E2IR, UIR, SDR};

   logic iclk = 1'b0;
   logic ireset, tck, tms, tdi, trst;
   logic tdo, tdo_oe, bsr_sdi, bsr_sdo, mode, shift_dr, clk_dr, update_dr;
   logic [IRW-1:0] ir;

   always #5 iclk = ~iclk;

   dp_tap_ctrl #(.IR_WIDTH(IRW)) dut (
      .iclk(iclk), .ireset(ireset), .tck(tck), .tms(tms), .tdi(tdi),
`ifdef DP_TAP_TRST_EN
      .trst(trst),
`endif
      .tdo(tdo), .tdo_oe(tdo_oe), .bsr_sdi(bsr_sdi), .bsr_sdo(bsr_sdo),
      .mode(mode), .shift_dr(shift_dr), .clk_dr(clk_dr),
      .update_dr(update_dr), .ir(ir)
   );

   // 8-bit boundary-scan chain stub driven by the DUT strobes
   logic [7:0] bsr_sh = 8'h00, bsr_upd = 8'h00;
   int n_clk = 0, n_upd = 0;
   always @(posedge iclk) begin
      if (clk_dr === 1'b1) begin
         bsr_sh <= shift_dr ? {bsr_sdi, bsr_sh[7:1]} : PINS;
         n_clk  <= n_clk + 1;
      end
      if (update_dr === 1'b1) begin
         bsr_upd <= bsr_sh;
         n_upd   <= n_upd + 1;
      end
   end
   assign bsr_sdo = bsr_sh[0];

   // edge-level reference model
   int m_st;
   bit [IRW-1:0] m_ir, m_irsr;
   bit m_byp, m_tdi, m_tdo, m_oe;
   bit [7:0] m_bsr = 8'h00;
   // expected DUT outputs at the current cycle
   bit e_tdo, e_oe, e_sdi, e_shift, e_clk, e_upd;
   bit [IRW-1:0] e_ir;
   bit chk_en = 1'b0;
   int n_cmp = 0, n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_st = TLR; m_ir = BYPC; m_irsr = '0; m_byp = 0; m_tdi = 0; m_tdo = 0; m_oe = 0;
      e_tdo = 0; e_oe = 0; e_sdi = 0; e_shift = 0; e_clk = 0; e_upd = 0; e_ir = BYPC;
   endtask

   // drive one TCK edge just after a posedge; DUT outputs follow 3 posedges later
   task automatic tck_edge(input bit v);
      int pre;
      bit sel, p_clk, p_upd;
      tck = v;
      pre = m_st;
      sel = (m_ir == 0) || (m_ir == 1);
      p_clk = 0; p_upd = 0;
      if (v) begin
         p_clk = sel && (pre == CDR || pre == SHDR);
         case (pre)
            CIR:  m_irsr = 1;
            SHIR: m_irsr = {tdi, m_irsr[IRW-1:1]};
            CDR:  begin m_byp = 0; if (sel) m_bsr = PINS; end
            SHDR: begin m_byp = tdi; if (sel) m_bsr = {tdi, m_bsr[7:1]}; end
            default: ;
         endcase
         m_tdi = tdi;
         m_st = tms ? NX1[pre] : NX0[pre];
         if (m_st == TLR) m_ir = BYPC;
      end else begin
         p_upd = sel && (pre == UDR);
         if (pre == UIR) m_ir = m_irsr;
         m_oe  = (pre == SHIR) || (pre == SHDR);
         m_tdo = (pre == SHIR) ? m_irsr[0] : (pre == SHDR) ? (sel ? m_bsr[0] : m_byp) : 1'b0;
      end
      repeat (3) @(posedge iclk);
      #1;
      e_tdo = m_tdo; e_oe = m_oe; e_sdi = m_tdi; e_ir = m_ir;
      e_clk = p_clk; e_upd = p_upd; e_shift = (pre == SHDR);
      @(posedge iclk);
      #1;
      e_clk = 0; e_upd = 0; e_shift = (m_st == SHDR);
      repeat ($urandom_range(0, 2)) @(posedge iclk);
      #1;
   endtask

   task automatic cycle(input bit tms_v, input bit tdi_v);
      tms = tms_v;
      tdi = tdi_v;
      tck_edge(1'b1);
      tck_edge(1'b0);
   endtask

   task automatic goto_rti();
      repeat (5) cycle(1'b1, 1'($urandom));
      cycle(1'b0, 1'b0);
   endtask

   task automatic scan_ir(input bit [IRW-1:0] code, output bit [IRW-1:0] cap);
      cycle(1, 0); cycle(1, 0); cycle(0, 0); cycle(0, 0);
      for (int i = 0; i < IRW; i++) begin
         cap[i] = tdo;
         cycle(i == IRW-1, code[i]);
      end
      cycle(1, 0); cycle(0, 0);
   endtask

   task automatic scan_dr(input bit [31:0] din, input int n, output bit [31:0] dout);
      dout = '0;
      cycle(1, 0); cycle(0, 0); cycle(0, 0);
      for (int i = 0; i < n; i++) begin
         dout[i] = tdo;
         cycle(i == n-1, din[i]);
      end
      cycle(1, 0); cycle(0, 0);
   endtask

   task automatic do_reset();
      ireset = 1'b1;
      model_reset();
      #1;
      check("ireset ir", 32'(ir), 32'(BYPC));
      @(posedge iclk); #1;
      check("ireset tdo_oe", 32'(tdo_oe), 32'd0);
      ireset = 1'b0;
      @(posedge iclk); #1;
   endtask

   initial begin
      bit [IRW-1:0] cap;
      bit [31:0] dout, din;
      bit [IRW-1:0] code;
      int b_clk, b_upd, len;

      ireset = 0; tck = 0; tms = 0; tdi = 0; trst = 0;
      model_reset();
      fork
         forever begin
            @(negedge iclk);
            if (chk_en)
               check("cycle {tdo,oe,sdi,mode,shift,clk,upd,ir}",
                     32'({tdo, tdo_oe, bsr_sdi, mode, shift_dr, clk_dr, update_dr, ir}),
                     32'({e_tdo, e_oe, e_sdi, (e_ir == 0), e_shift, e_clk, e_upd, e_ir}));
         end
      join_none

      #1 ireset = 1'b1;
      repeat (3) @(posedge iclk);
      #1;
      chk_en = 1'b1;
      check("reset ir", 32'(ir), 32'hF);
      check("reset outs", 32'({tdo, tdo_oe, bsr_sdi, mode, shift_dr, clk_dr, update_dr}), 32'd0);
      ireset = 1'b0;
      @(posedge iclk); #1;

      b_clk = n_clk; b_upd = n_upd;
      repeat (5) cycle(1'b1, 1'($urandom));
      check("tlr ir", 32'(ir), 32'hF);
      check("tlr tdo_oe", 32'(tdo_oe), 32'd0);
      check("tlr strobes", 32'((n_clk - b_clk) + (n_upd - b_upd)), 32'd0);

      cycle(0, 0);
      scan_ir(4'h0, cap);
      check("extest ir capture", 32'(cap), 32'b0001);
      check("extest ir", 32'(ir), 32'h0);
      check("extest mode", 32'(mode), 32'd1);

      b_clk = n_clk; b_upd = n_upd;
      scan_dr(32'hA5, 8, dout);
      check("extest tdo word", dout, 32'(PINS));
      check("extest clk_dr count", 32'(n_clk - b_clk), 32'd9);
      check("extest update_dr count", 32'(n_upd - b_upd), 32'd1);
      check("extest bsr update", 32'(bsr_upd), 32'hA5);

      scan_ir(4'hF, cap);
      check("bypass ir", 32'(ir), 32'hF);
      check("bypass mode", 32'(mode), 32'd0);
      b_clk = n_clk; b_upd = n_upd;
      scan_dr(32'b1101, 4, dout);
      check("bypass tdo seq", dout, 32'b1010);
      check("bypass strobes", 32'((n_clk - b_clk) + (n_upd - b_upd)), 32'd0);

      scan_ir(4'h0, cap);
      b_upd = n_upd;
      cycle(1, 0); cycle(0, 0); cycle(0, 0);
      repeat (3) cycle(0, 1'($urandom));
      do_reset();
      check("reset mid-scan no update", 32'(n_upd - b_upd), 32'd0);

`ifdef DP_TAP_TRST_EN
      goto_rti();
      cycle(1, 0); cycle(1, 0); cycle(0, 0); cycle(1, 0); cycle(0, 0);
      trst = 1'b1;
      @(posedge iclk); @(posedge iclk); #1;
      trst = 1'b0;
      @(posedge iclk); #1;
      model_reset();
      check("trst ir", 32'(ir), 32'hF);
      repeat (3) @(posedge iclk); #1;
`endif

      for (int k = 0; k < 12; k++) begin
         goto_rti();
         code = 4'($urandom);
         if (k % 3 == 0) code = 4'h0;
         if (k % 3 == 1) code = 4'h1;
         scan_ir(code, cap);
         check("random ir capture", 32'(cap), 32'b0001);
         check("random ir", 32'(ir), 32'(code));
         len = $urandom_range(1, 12);
         din = $urandom;
         scan_dr(din, len, dout);
         repeat (20) cycle($urandom_range(0, 99) < 35, 1'($urandom));
         if (k == 6) do_reset();
      end

      repeat (4) @(posedge iclk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
